// File: rtl/eurorack_i2c_pkg.sv
// Shared types and constants for the eurorack_pmod I2C subsystem.
package eurorack_i2c_pkg;

  localparam int unsigned DEV_W  = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TO_W   = 16;

  // On-board I2C device addresses (7-bit)
  localparam logic [DEV_W-1:0] CODEC_DEV  = 7'h10;
  localparam logic [DEV_W-1:0] EEPROM_DEV = 7'h52;
  localparam logic [DEV_W-1:0] LED_DEV    = 7'h05;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } arb_state_t;

  typedef struct packed {
    logic [DEV_W-1:0]  dev;
    logic [BYTE_W-1:0] reg_addr;
    logic [BYTE_W-1:0] wdata;
    logic              rnw;
  } i2c_txn_t;

  function automatic i2c_txn_t make_txn(
    input logic [DEV_W-1:0]  dev,
    input logic [BYTE_W-1:0] reg_addr,
    input logic [BYTE_W-1:0] wdata,
    input logic              rnw
  );
    i2c_txn_t t;
    t.dev      = dev;
    t.reg_addr = reg_addr;
    t.wdata    = wdata;
    t.rnw      = rnw;
    return t;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and I2C-master-side signals of the transaction arbiter.
// master: the arbiter's view; slave: requesters plus byte-level I2C master.
interface i2c_txn_arbiter_if #(
  parameter int unsigned N = 3
);
  import eurorack_i2c_pkg::*;

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [DEV_W*N-1:0]  req_dev;
  logic [BYTE_W*N-1:0] req_reg;
  logic [BYTE_W*N-1:0] req_wdata;
  logic [N-1:0]        req_rnw;
  logic [N-1:0]        rsp_valid;
  logic [BYTE_W-1:0]   rsp_rdata;
  logic                rsp_err;

  logic                mst_valid;
  logic                mst_ready;
  logic [DEV_W-1:0]    mst_dev;
  logic [BYTE_W-1:0]   mst_reg;
  logic [BYTE_W-1:0]   mst_wdata;
  logic                mst_rnw;
  logic                mst_done;
  logic [BYTE_W-1:0]   mst_rdata;
  logic                mst_nack;
  logic                mst_abort;

  modport master (
    input  req_valid, req_dev, req_reg, req_wdata, req_rnw,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mst_valid, mst_dev, mst_reg, mst_wdata, mst_rnw, mst_abort,
    input  mst_ready, mst_done, mst_rdata, mst_nack
  );

  modport slave (
    output req_valid, req_dev, req_reg, req_wdata, req_rnw,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mst_valid, mst_dev, mst_reg, mst_wdata, mst_rnw, mst_abort,
    output mst_ready, mst_done, mst_rdata, mst_nack
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set valid bit searching upward,
// with wrap, from (ptr+1) mod N.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner_c,
  output logic                 found_c
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    idx      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!found_c && valid[idx]) begin
        winner_c = idx;
        found_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master between N requesters.
// Optional command timeout/abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
  import eurorack_i2c_pkg::*;
#(
  parameter int unsigned N              = 3,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_256fs,
  input  logic                 rst_n,
  i2c_txn_arbiter_if.master    bus,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("i2c_txn_arbiter: N must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("i2c_txn_arbiter: TIMEOUT_CYCLES must be 1..65536");
  end

  // Unpack per-requester fields into transaction records
  i2c_txn_t req_txn [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_txn[i] = make_txn(bus.req_dev[DEV_W*i +: DEV_W],
                                 bus.req_reg[BYTE_W*i +: BYTE_W],
                                 bus.req_wdata[BYTE_W*i +: BYTE_W],
                                 bus.req_rnw[i]);
  end

  // grant_id doubles as the round-robin pointer; it resets to 0, so under
  // full contention from reset the first grant goes to requester 1.
  logic [IW-1:0] win_c;
  logic          found_c;

  rr_pick #(.N(N)) u_rr_pick (
    .valid    (bus.req_valid),
    .ptr      (grant_id),
    .winner_c (win_c),
    .found_c  (found_c)
  );

  arb_state_t        state, state_nx;
  i2c_txn_t          txn, txn_nx;
  logic [IW-1:0]     grant_nx;
  logic              mst_valid, mst_valid_nx;
  logic [N-1:0]      req_ready, req_ready_nx;
  logic [N-1:0]      rsp_valid, rsp_valid_nx;
  logic [BYTE_W-1:0] rsp_rdata, rsp_rdata_nx;
  logic              rsp_err, rsp_err_nx;
  logic [GW-1:0]     gap_cnt, gap_cnt_nx;
  logic              busy_nx;
  logic              timeout_c;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            mst_abort;

  // Held at 0 while idle so it reads 0 on the first ISSUE cycle
  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (state == ISSUE || state == WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // A completion in the expiry cycle wins over the abort
  assign timeout_c = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) &&
                     ((state == ISSUE) || (state == WAIT && !bus.mst_done));

  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      mst_abort <= 1'b0;
    end else begin
      mst_abort <= timeout_c;
    end
  end

  assign bus.mst_abort = mst_abort;
`else
  assign timeout_c     = 1'b0;
  assign bus.mst_abort = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    txn_nx       = txn;
    grant_nx     = grant_id;
    mst_valid_nx = mst_valid;
    req_ready_nx = '0;
    rsp_valid_nx = '0;
    rsp_rdata_nx = '0;
    rsp_err_nx   = 1'b0;
    gap_cnt_nx   = gap_cnt;

    unique case (state)
      IDLE: begin
        if (found_c) begin
          state_nx     = ISSUE;
          txn_nx       = req_txn[win_c];
          grant_nx     = win_c;
          mst_valid_nx = 1'b1;
          req_ready_nx = N'(1) << win_c;
        end
      end

      ISSUE: begin
        if (timeout_c) begin
          state_nx     = RESP;
          mst_valid_nx = 1'b0;
          rsp_valid_nx = N'(1) << grant_id;
          rsp_err_nx   = 1'b1;
        end else if (bus.mst_ready) begin
          state_nx     = WAIT;
          mst_valid_nx = 1'b0;
        end
      end

      WAIT: begin
        if (bus.mst_done) begin
          state_nx     = RESP;
          rsp_valid_nx = N'(1) << grant_id;
          rsp_rdata_nx = txn.rnw ? bus.mst_rdata : '0;
          rsp_err_nx   = bus.mst_nack;
        end else if (timeout_c) begin
          state_nx     = RESP;
          rsp_valid_nx = N'(1) << grant_id;
          rsp_err_nx   = 1'b1;
        end
      end

      RESP: begin
        gap_cnt_nx = '0;
        state_nx   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end

      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      state     <= IDLE;
      txn       <= '0;
      grant_id  <= '0;
      mst_valid <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      txn       <= txn_nx;
      grant_id  <= grant_nx;
      mst_valid <= mst_valid_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      gap_cnt   <= gap_cnt_nx;
      busy      <= busy_nx;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.mst_valid = mst_valid;
  assign bus.mst_dev   = txn.dev;
  assign bus.mst_reg   = txn.reg_addr;
  assign bus.mst_wdata = txn.wdata;
  assign bus.mst_rnw   = txn.rnw;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: table of single transactions plus
// directed sequences for fairness, withdrawal, reset mid-transaction and timeout.
module tb_i2c_txn_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned GAP = 4;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TO  = 100;
`else
  localparam int unsigned TO  = 65535;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;

  int n_cmp = 0;
  int n_err = 0;

  i2c_txn_arbiter_if #(.N(N)) bus ();

  i2c_txn_arbiter #(.N(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk_256fs (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       rnw;
    logic [7:0] m_rdata;
    logic       m_nack;
    int         rdy_dly;
    int         done_dly;
    bit         early;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // At most one requester may see ready/response at any time
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if ($countones(bus.req_ready) > 1 || $countones(bus.rsp_valid) > 1) begin
        n_err++;
        $display("FAIL onehot: req_ready 0x%0h rsp_valid 0x%0h", bus.req_ready, bus.rsp_valid);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 300 && busy; k++) tick();
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    wait_idle();
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    bus.req_dev[7*v.id +: 7]   = v.dev;
    bus.req_reg[8*v.id +: 8]   = v.rg;
    bus.req_wdata[8*v.id +: 8] = v.wd;
    bus.req_rnw[v.id]          = v.rnw;
    tick();
    check("req_ready", 32'(bus.req_ready), 32'(1) << v.id);
    check("grant_id", 32'(grant_id), 32'(v.id));
    check("mst_valid", 32'(bus.mst_valid), 32'd1);
    check("mst_dev", 32'(bus.mst_dev), 32'(v.dev));
    check("mst_reg", 32'(bus.mst_reg), 32'(v.rg));
    check("mst_wdata", 32'(bus.mst_wdata), 32'(v.wd));
    check("mst_rnw", 32'(bus.mst_rnw), 32'(v.rnw));
    bus.req_valid = '0;
    for (int i = 0; i < v.rdy_dly; i++) begin
      if (v.early && i == 0) bus.mst_done = 1'b1;
      tick();
      bus.mst_done = 1'b0;
      check("hold_valid", 32'(bus.mst_valid), 32'd1);
      check("hold_dev", 32'(bus.mst_dev), 32'(v.dev));
      check("ready_once", 32'(bus.req_ready), 32'd0);
      check("no_rsp_issue", 32'(bus.rsp_valid), 32'd0);
    end
    bus.mst_ready = 1'b1;
    tick();
    bus.mst_ready = 1'b0;
    check("mst_valid_drop", 32'(bus.mst_valid), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    for (int i = 0; i < v.done_dly; i++) begin
      tick();
      check("no_rsp_wait", 32'(bus.rsp_valid), 32'd0);
    end
    bus.mst_done  = 1'b1;
    bus.mst_rdata = v.m_rdata;
    bus.mst_nack  = v.m_nack;
    tick();
    bus.mst_done  = 1'b0;
    bus.mst_rdata = '0;
    bus.mst_nack  = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << v.id);
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (k == 0) check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
      if (!busy) break;
      n++;
    end
    check("gap_len", 32'(n), 32'(GAP));
  endtask

  // Complete whichever requester gets granted, then re-raise its request
  task automatic serve(output int id);
    id = -1;
    for (int k = 0; k < 200 && bus.req_ready == '0; k++) tick();
    check("grant_seen", 32'(|bus.req_ready), 32'd1);
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) id = i;
    if (id < 0) return;
    bus.req_valid[id] = 1'b0;
    bus.mst_ready = 1'b1;
    tick();
    bus.mst_ready = 1'b0;
    bus.mst_done  = 1'b1;
    tick();
    bus.mst_done  = 1'b0;
    check("serve_rsp", 32'(bus.rsp_valid), 32'(1) << id);
    bus.req_valid[id] = 1'b1;
  endtask

  initial begin
    int order [6] = '{1, 2, 0, 1, 2, 0};
    int gid;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_dev   = '0;
    bus.req_reg   = '0;
    bus.req_wdata = '0;
    bus.req_rnw   = '0;
    bus.mst_ready = 1'b0;
    bus.mst_done  = 1'b0;
    bus.mst_rdata = '0;
    bus.mst_nack  = 1'b0;

    vecs[0] = '{id:0, dev:7'h11, rg:8'h02, wd:8'hA5, rnw:1'b0, m_rdata:8'h77, m_nack:1'b0,
                rdy_dly:3, done_dly:2, early:1'b0, exp_rdata:8'h00, exp_err:1'b0};
    vecs[1] = '{id:2, dev:7'h52, rg:8'h00, wd:8'h00, rnw:1'b1, m_rdata:8'h3C, m_nack:1'b0,
                rdy_dly:0, done_dly:0, early:1'b0, exp_rdata:8'h3C, exp_err:1'b0};
    vecs[2] = '{id:1, dev:7'h10, rg:8'h05, wd:8'h0F, rnw:1'b0, m_rdata:8'h99, m_nack:1'b1,
                rdy_dly:1, done_dly:1, early:1'b0, exp_rdata:8'h00, exp_err:1'b1};
    vecs[3] = '{id:0, dev:7'h05, rg:8'h80, wd:8'h00, rnw:1'b1, m_rdata:8'hC3, m_nack:1'b1,
                rdy_dly:0, done_dly:3, early:1'b0, exp_rdata:8'hC3, exp_err:1'b1};
    vecs[4] = '{id:1, dev:7'h52, rg:8'h10, wd:8'h00, rnw:1'b1, m_rdata:8'h5A, m_nack:1'b0,
                rdy_dly:2, done_dly:0, early:1'b1, exp_rdata:8'h5A, exp_err:1'b0};

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mst_valid", 32'(bus.mst_valid), 32'd0);
    check("rst_mst_fields", {bus.mst_dev, bus.mst_reg, bus.mst_wdata, bus.mst_rnw}, 32'd0);
    check("rst_mst_abort", 32'(bus.mst_abort), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Fairness from reset, then withdrawal of requester 1 before its turn
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      serve(gid);
      check($sformatf("rr_order_%0d", k), 32'(gid), 32'(order[k]));
    end
    bus.req_valid[1] = 1'b0;
    serve(gid);
    check("rr_withdraw", 32'(gid), 32'd2);
    bus.req_valid = '0;
    wait_idle();

    // Reset in the middle of WAIT drops the transaction silently
    bus.req_valid = 3'b010;
    tick();
    check("mid_grant", 32'(bus.req_ready), 32'b010);
    bus.req_valid = '0;
    bus.mst_ready = 1'b1;
    tick();
    bus.mst_ready = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_outs", {bus.mst_valid, bus.mst_abort, bus.rsp_err, bus.rsp_valid, grant_id,
                           bus.req_ready, bus.rsp_rdata}, 32'd0);
    bus.mst_done  = 1'b1;
    bus.mst_rdata = 8'hEE;
    tick();
    bus.mst_done  = 1'b0;
    bus.mst_rdata = '0;
    check("mid_stale_done", 32'(bus.rsp_valid), 32'd0);
    check("mid_still_idle", 32'(busy), 32'd0);
    bus.req_valid = 3'b001;
    tick();
    check("mid_req0_grant", 32'(bus.req_ready), 32'b001);
    check("mid_req0_id", 32'(grant_id), 32'd0);
    bus.req_valid = '0;
    bus.mst_ready = 1'b1;
    tick();
    bus.mst_ready = 1'b0;
    bus.mst_done  = 1'b1;
    tick();
    bus.mst_done  = 1'b0;
    check("mid_req0_rsp", 32'(bus.rsp_valid), 32'b001);
    wait_idle();

`ifdef I2C_ARB_TIMEOUT_EN
    // Two runs: no completion (abort), then completion exactly at expiry
    for (int run = 0; run < 2; run++) begin
      wait_idle();
      bus.req_valid    = 3'b001;
      bus.req_rnw[0]   = (run == 1);
      tick();
      check("to_grant", 32'(bus.req_ready), 32'b001);
      bus.req_valid = '0;
      bus.mst_ready = 1'b1;
      tick();
      bus.mst_ready = 1'b0;
      repeat (98) tick();
      check("to_pre_abort", 32'(bus.mst_abort), 32'd0);
      check("to_pre_rsp", 32'(bus.rsp_valid), 32'd0);
      if (run == 1) begin
        bus.mst_done  = 1'b1;
        bus.mst_rdata = 8'h42;
      end
      tick();
      bus.mst_done  = 1'b0;
      bus.mst_rdata = '0;
      check("to_abort", 32'(bus.mst_abort), (run == 0) ? 32'd1 : 32'd0);
      check("to_rsp", 32'(bus.rsp_valid), 32'b001);
      check("to_err", 32'(bus.rsp_err), (run == 0) ? 32'd1 : 32'd0);
      check("to_rdata", 32'(bus.rsp_rdata), (run == 0) ? 32'h00 : 32'h42);
      tick();
      check("to_abort_pulse", 32'(bus.mst_abort), 32'd0);
    end
    bus.req_rnw = '0;
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
